uart_tx_periph: RTL and testbench

Memory-mapped UART transmitter peripheral that consumes the write-enables produced by the data-bus write decoder: `we_ctrl_uart` for the control register at 0x2020 and `we_data_uart` for the data register at 0x2024. The CPU loads a byte into the data register, then sets the send bit in the control register. The block serialises the byte as an 8N1 frame on `tx_o` and clears the send bit when the frame is done. Register contents are returned to the read multiplexer through `ctrl_o` and `data_o`.

---
 rtl/uart_tx_periph_if.sv | 37 +++
 rtl/uart_tx_periph.sv | 169 ++++++++++++++++
 tb/tb_uart_tx_periph.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_periph_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_periph_if
// Purpose  : Bus-side signal bundle between the data-bus write decoder / read
//            multiplexer and the UART transmitter peripheral.
// Signals  : we_ctrl_i  - write-enable, control register (0x2020)
//            we_data_i  - write-enable, data register (0x2024)
//            wdata_i    - 32-bit CPU store data
//            ctrl_o     - control register readback {31'b0, send}
//            data_o     - data register readback {24'b0, data}
// Modports : master - decoder / CPU side, slave - peripheral side
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_periph_if;
   logic        we_ctrl_i;
   logic        we_data_i;
   logic [31:0] wdata_i;
   logic [31:0] ctrl_o;
   logic [31:0] data_o;

   modport master (
      output we_ctrl_i,
      output we_data_i,
      output wdata_i,
      input  ctrl_o,
      input  data_o
   );

   modport slave (
      input  we_ctrl_i,
      input  we_data_i,
      input  wdata_i,
      output ctrl_o,
      output data_o
   );
endinterface
`default_nettype wire

// File: rtl/uart_tx_periph.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_periph
// Purpose  : Memory-mapped UART transmitter. The CPU loads a byte into the
//            data register, then sets the send bit in the control register;
//            the byte is serialised LSB-first on tx_o and send clears when
//            the stop bit ends. Register writes are ignored while busy.
// Ports    : clk_i    - system clock, rising edge
//            rst_n_i  - asynchronous active-low reset
//            bus      - uart_tx_periph_if.slave (write enables, store data,
//                       ctrl/data readback)
//            tx_o     - registered serial line, idle high
// Params   : CLKS_PER_BIT - clock cycles per bit (>= 2)
// Options  : UART_PARITY_EN - when defined, an even parity bit is inserted
//            between the data bits and the stop bit (8E1 instead of 8N1).
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_periph #(
   parameter int CLKS_PER_BIT = 1042
) (
   input  wire logic         clk_i,
   input  wire logic         rst_n_i,
   uart_tx_periph_if.slave   bus,
   output      logic         tx_o
);

   localparam int c_CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [c_CW-1:0] c_CNT_MAX = c_CW'(CLKS_PER_BIT - 1);

`ifdef UART_PARITY_EN
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;
`endif

   state_t          r_state;
   logic [c_CW-1:0] r_cnt;
   logic [2:0]      r_idx;
   logic [7:0]      r_shift;
   logic [7:0]      r_data;
   logic            r_send;
   logic            r_tx;

   logic            w_idle;
   logic            w_bit_end;
   logic            w_start;
   logic            w_data_wr;

   assign w_idle    = (r_state == S_IDLE);
   assign w_bit_end = (r_cnt == c_CNT_MAX);
   assign w_start   = w_idle && bus.we_ctrl_i && bus.wdata_i[0];
   // A control write in the same cycle takes precedence and drops the data
   // write, even when it does not start a frame.
   assign w_data_wr = w_idle && bus.we_data_i && !bus.we_ctrl_i;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_idx   <= 3'd0;
         r_shift <= 8'h00;
         r_data  <= 8'h00;
         r_send  <= 1'b0;
         r_tx    <= 1'b1;
      end else begin
         if (w_data_wr) begin
            r_data <= bus.wdata_i[7:0];
         end

         case (r_state)
            S_IDLE: begin
               r_cnt <= '0;
               if (w_start) begin
                  // Line drops on the same edge that accepts the write.
                  r_send  <= 1'b1;
                  r_shift <= r_data;
                  r_tx    <= 1'b0;
                  r_state <= S_START;
               end
            end

            S_START: begin
               if (w_bit_end) begin
                  r_cnt   <= '0;
                  r_idx   <= 3'd0;
                  r_tx    <= r_shift[0];
                  r_shift <= {1'b0, r_shift[7:1]};
                  r_state <= S_DATA;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            S_DATA: begin
               if (w_bit_end) begin
                  r_cnt <= '0;
                  if (r_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                     // Data register is frozen while busy, so it still
                     // holds the byte being sent.
                     r_tx    <= ^r_data;
                     r_state <= S_PARITY;
`else
                     r_tx    <= 1'b1;
                     r_state <= S_STOP;
`endif
                  end else begin
                     r_idx   <= r_idx + 3'd1;
                     r_tx    <= r_shift[0];
                     r_shift <= {1'b0, r_shift[7:1]};
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

`ifdef UART_PARITY_EN
            S_PARITY: begin
               if (w_bit_end) begin
                  r_cnt   <= '0;
                  r_tx    <= 1'b1;
                  r_state <= S_STOP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
`endif

            S_STOP: begin
               if (w_bit_end) begin
                  r_cnt   <= '0;
                  r_send  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            default: begin
               r_cnt   <= '0;
               r_send  <= 1'b0;
               r_tx    <= 1'b1;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.ctrl_o = {31'b0, r_send};
   assign bus.data_o = {24'b0, r_data};
   assign tx_o       = r_tx;

   // Upper store-data bits carry no meaning for either register.
   logic w_unused_wdata;
   assign w_unused_wdata = &{1'b0, bus.wdata_i[31:8]};

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_periph.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_periph
// Purpose  : Self-checking bench for uart_tx_periph with CLKS_PER_BIT = 4.
//            Stimulus pushes the expected serial frame into a queue; a line
//            monitor detects each start bit, pops the expectation and checks
//            every bit near its centre. Register readback, frame length,
//            busy-write rejection, back-to-back spacing and asynchronous
//            reset are checked directly by the stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_periph;

   localparam int c_CPB = 4;
`ifdef UART_PARITY_EN
   localparam int c_NBITS = 11;
`else
   localparam int c_NBITS = 10;
`endif
   localparam int c_LEN = c_NBITS * c_CPB;

   logic clk;
   logic rst_n;
   logic tx_o;

   uart_tx_periph_if bus_if ();

   uart_tx_periph #(
      .CLKS_PER_BIT (c_CPB)
   ) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus_if.slave),
      .tx_o    (tx_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [10:0] sb[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Frame bit vector, bit 0 = start bit. Parity supplied hand-computed.
   function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic p);
`ifdef UART_PARITY_EN
      return {1'b1, p, d, 1'b0};
`else
      return {1'b1, 1'b1, d, 1'b0};
`endif
   endfunction

   // ---------------- line monitor ----------------
   task automatic check_frame();
      logic [10:0] exp;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_frame: start bit seen, no frame expected at %0t", $time);
         return;
      end
      exp = sb.pop_front();
      for (int k = 0; k < c_NBITS; k++) begin
         if (k == 0) @(negedge clk);
         else repeat (c_CPB) @(negedge clk);
         if (!rst_n) return;   // frame aborted by reset
         chk($sformatf("frame_bit%0d", k), 32'(tx_o), 32'(exp[k]));
      end
   endtask

   initial begin
      logic prev;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         if (rst_n && prev && !tx_o) check_frame();
         prev = tx_o;
      end
   end

   // ---------------- stimulus helpers (entered just after a negedge) ----------------
   task automatic wr_ctrl(input logic [31:0] v);
      bus_if.we_ctrl_i = 1'b1;
      bus_if.wdata_i   = v;
      @(negedge clk);
      bus_if.we_ctrl_i = 1'b0;
      bus_if.wdata_i   = 32'h0;
   endtask

   task automatic wr_data(input logic [31:0] v);
      bus_if.we_data_i = 1'b1;
      bus_if.wdata_i   = v;
      @(negedge clk);
      bus_if.we_data_i = 1'b0;
      bus_if.wdata_i   = 32'h0;
   endtask

   // Counts cycles with send set; optionally issues writes while busy.
   task automatic wait_frame(input bit busy, input logic [7:0] d);
      int n;
      bit ok;
      n  = 0;
      ok = 1'b1;
      while (bus_if.ctrl_o == 32'h1 && n < 100) begin
         if (bus_if.data_o !== {24'h0, d}) ok = 1'b0;
         if (busy) begin
            bus_if.we_data_i = (n == 10);
            bus_if.we_ctrl_i = (n == 20);
            bus_if.wdata_i   = (n == 10) ? 32'hFFFF_FF3C : 32'h0;
         end
         n++;
         @(negedge clk);
      end
      bus_if.we_data_i = 1'b0;
      bus_if.we_ctrl_i = 1'b0;
      bus_if.wdata_i   = 32'h0;
      chk("frame_len", 32'(n), 32'(c_LEN));
      chk("data_hold", 32'(ok), 32'd1);
      chk("ctrl_clear", bus_if.ctrl_o, 32'h0);
   endtask

   task automatic idle_check(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         chk("idle_tx", 32'(tx_o), 32'd1);
         @(negedge clk);
      end
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, errors so far %0d", errors);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1, "timeout");
   end

   // ---------------- main sequence ----------------
   initial begin
      rst_n            = 1'b0;
      bus_if.we_ctrl_i = 1'b0;
      bus_if.we_data_i = 1'b0;
      bus_if.wdata_i   = 32'h0;
      repeat (3) @(negedge clk);
      chk("rst_tx", 32'(tx_o), 32'd1);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_ctrl", bus_if.ctrl_o, 32'h0);
      chk("rst_data", bus_if.data_o, 32'h0);
      idle_check(20);

      // Basic frame 0xA5 (parity 0) with writes while busy.
      wr_data(32'hFFFF_FFA5);
      chk("data_rb", bus_if.data_o, 32'h0000_00A5);
      sb.push_back(frame_bits(8'hA5, 1'b0));
      wr_ctrl(32'hFFFF_FFFF);
      chk("ctrl_rb", bus_if.ctrl_o, 32'h1);
      chk("start_latency", 32'(tx_o), 32'd0);
      wait_frame(1'b1, 8'hA5);

      // Back-to-back: write in the first idle cycle -> one idle-high cycle.
      chk("b2b_gap", 32'(tx_o), 32'd1);
      sb.push_back(frame_bits(8'hA5, 1'b0));
      wr_ctrl(32'h1);
      chk("b2b_start", 32'(tx_o), 32'd0);
      wait_frame(1'b0, 8'hA5);
      idle_check(3);

      // Frame 0x07 (parity 1).
      wr_data(32'h0000_0007);
      sb.push_back(frame_bits(8'h07, 1'b1));
      wr_ctrl(32'h1);
      wait_frame(1'b0, 8'h07);
      idle_check(3);

      // Simultaneous ctrl+data write: ctrl wins, data 0x01 dropped, 0x07 sent.
      // Then reset during data bit 3 (0 for 0x07).
      sb.push_back(frame_bits(8'h07, 1'b1));
      bus_if.we_ctrl_i = 1'b1;
      bus_if.we_data_i = 1'b1;
      bus_if.wdata_i   = 32'h0000_0001;
      @(negedge clk);
      bus_if.we_ctrl_i = 1'b0;
      bus_if.we_data_i = 1'b0;
      bus_if.wdata_i   = 32'h0;
      chk("both_wr_data", bus_if.data_o, 32'h0000_0007);
      chk("both_wr_ctrl", bus_if.ctrl_o, 32'h1);
      repeat (17) @(negedge clk);
      chk("pre_rst_tx", 32'(tx_o), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_tx", 32'(tx_o), 32'd1);
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_ctrl", bus_if.ctrl_o, 32'h0);
      chk("post_rst_data", bus_if.data_o, 32'h0);
      idle_check(20);

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
